// File: rtl/pc_wala_mux_pkg.sv
// Shared core package: address type and the saturating-increment helper.
package pc_wala_mux_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   // Increment that holds at max_val instead of wrapping.
   function automatic addr_t sat_inc(input addr_t count, input addr_t max_val);
      return (count == max_val) ? count : count + XLEN'(1);
   endfunction

endpackage

// File: rtl/pc_wala_mux_sat_counter.sv
// Enable-gated counter that sticks at all-ones; async active-low clear.
module pc_wala_mux_sat_counter
   import pc_wala_mux_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   localparam addr_t CNT_MAX = XLEN'((64'(1) << CNT_W) - 64'(1));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_next;

   assign w_next = CNT_W'(sat_inc(XLEN'(r_cnt), CNT_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_next;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_wala_mux.sv
// Next-PC select (branch target when branch & zero_flag, else PC+4) with
// registered branch/taken statistics for debug readout.
module pc_wala_mux
   import pc_wala_mux_pkg::*;
#(
   parameter int unsigned WIDTH = XLEN,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] sum,
   input  logic             branch,
   input  logic             zero_flag,
   output logic [WIDTH-1:0] res,
   output logic             taken,
   output logic             taken_q,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   logic w_taken;
   logic r_taken_q;

   // Mux path is purely combinational and never sees reset.
   assign w_taken = branch & zero_flag;
   assign taken   = w_taken;
   assign res     = w_taken ? sum : addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_q <= 1'b0;
      end else begin
         r_taken_q <= w_taken;
      end
   end

   assign taken_q = r_taken_q;

   pc_wala_mux_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (branch),
      .o_cnt (branch_cnt)
   );

   pc_wala_mux_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_taken),
      .o_cnt (taken_cnt)
   );

endmodule

// File: tb/tb_pc_wala_mux.sv
// Self-checking bench for pc_wala_mux: directed mux cases, reset behaviour,
// randomized traffic against a counting model, and 4-bit counter saturation.
module tb_pc_wala_mux;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned CNT_WS = 4;

   logic              clk;
   logic              rst_n;
   logic              rst_n_s;
   logic [WIDTH-1:0]  addr;
   logic [WIDTH-1:0]  sum;
   logic              branch;
   logic              zero_flag;
   logic [WIDTH-1:0]  res;
   logic              taken;
   logic              taken_q;
   logic [CNT_W-1:0]  branch_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   logic [WIDTH-1:0]  res_s;
   logic              taken_s;
   logic              taken_q_s;
   logic [CNT_WS-1:0] branch_cnt_s;
   logic [CNT_WS-1:0] taken_cnt_s;

   int checks   = 0;
   int failures = 0;

   // Reference model state for the main DUT
   int  m_bcnt;
   int  m_tcnt;
   bit  m_tq;
   localparam int M_MAX = (1 << CNT_W) - 1;

   pc_wala_mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .sum        (sum),
      .branch     (branch),
      .zero_flag  (zero_flag),
      .res        (res),
      .taken      (taken),
      .taken_q    (taken_q),
      .branch_cnt (branch_cnt),
      .taken_cnt  (taken_cnt)
   );

   pc_wala_mux #(.WIDTH(WIDTH), .CNT_W(CNT_WS)) dut_s (
      .clk        (clk),
      .rst_n      (rst_n_s),
      .addr       (addr),
      .sum        (sum),
      .branch     (branch),
      .zero_flag  (zero_flag),
      .res        (res_s),
      .taken      (taken_s),
      .taken_q    (taken_q_s),
      .branch_cnt (branch_cnt_s),
      .taken_cnt  (taken_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] exp_res(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] s,
                                                input bit b, input bit z);
      if (b && z) return s;
      return a;
   endfunction

   // Apply inputs just after an edge, check the mux, clock, then check state.
   task automatic step(input bit b, input bit z,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s,
                       input string tag);
      branch = b; zero_flag = z; addr = a; sum = s;
      #1;
      check({tag, ".res"},   64'(res),   64'(exp_res(a, s, b, z)));
      check({tag, ".taken"}, 64'(taken), 64'(b && z));
      @(posedge clk);
      if (rst_n) begin
         m_tq = b && z;
         if (b && m_bcnt < M_MAX) m_bcnt++;
         if (b && z && m_tcnt < M_MAX) m_tcnt++;
      end else begin
         m_tq = 0; m_bcnt = 0; m_tcnt = 0;
      end
      #1;
      check({tag, ".taken_q"},    64'(taken_q),    64'(m_tq));
      check({tag, ".branch_cnt"}, 64'(branch_cnt), 64'(m_bcnt));
      check({tag, ".taken_cnt"},  64'(taken_cnt),  64'(m_tcnt));
   endtask

   task automatic sweep(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] s,
                        input string tag);
      for (int i = 0; i < 4; i++) begin
         step(bit'(i >> 1), bit'(i & 1), a, s, $sformatf("%s.sel%0d", tag, i));
      end
   endtask

   initial begin
      rst_n = 1'b0; rst_n_s = 1'b0;
      branch = 1'b0; zero_flag = 1'b0; addr = '0; sum = '0;
      m_bcnt = 0; m_tcnt = 0; m_tq = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.taken_q",    64'(taken_q),    64'(0));
      check("reset.branch_cnt", 64'(branch_cnt), 64'(0));
      check("reset.taken_cnt",  64'(taken_cnt),  64'(0));

      // Mux behaviour while held in reset, counters must stay clear.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, bit'(i & 1), 32'h0000_1000, 32'h0000_2000, $sformatf("inrst%0d", i));
      end

      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, bit'(i & 1), 32'h0000_1000, 32'h0000_2000, $sformatf("alt%0d", i));
      end
      check("alt.branch_cnt8", 64'(branch_cnt), 64'(8));
      check("alt.taken_cnt4",  64'(taken_cnt),  64'(4));

      sweep(32'h0000_1000, 32'h0000_2000, "t1");
      sweep(32'hAAAA_AAAA, 32'h5555_5555, "t2");
      sweep(32'h0000_0000, 32'hFFFF_FFFF, "t3");
      step(1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678, "t4.sel0");
      step(1'b1, 1'b1, 32'h1234_5678, 32'h1234_5678, "t4.sel3");

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              $urandom, $urandom, $sformatf("rnd%0d", i));
         check($sformatf("rnd%0d.inv", i), 64'(taken_cnt <= branch_cnt), 64'(1));
      end

      // Asynchronous reset mid-operation, away from any edge.
      #2;
      rst_n = 1'b0;
      #1;
      m_bcnt = 0; m_tcnt = 0; m_tq = 0;
      check("async.taken_q",    64'(taken_q),    64'(0));
      check("async.branch_cnt", 64'(branch_cnt), 64'(0));
      check("async.taken_cnt",  64'(taken_cnt),  64'(0));
      branch = 1'b0; zero_flag = 1'b1; addr = 32'hDEAD_BEEF; sum = 32'h0BAD_F00D;
      #1;
      check("async.res", 64'(res), 64'(32'hDEAD_BEEF));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Saturation on the 4-bit instance.
      rst_n_s = 1'b1;
      branch = 1'b1; zero_flag = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("sat.branch_cnt", 64'(branch_cnt_s), 64'(4'hF));
      check("sat.taken_cnt",  64'(taken_cnt_s),  64'(4'hF));
      check("sat.taken_q",    64'(taken_q_s),    64'(1));
      #2;
      rst_n_s = 1'b0;
      #1;
      check("sat.clr.branch_cnt", 64'(branch_cnt_s), 64'(0));
      check("sat.clr.taken_cnt",  64'(taken_cnt_s),  64'(0));
      check("sat.clr.taken_q",    64'(taken_q_s),    64'(0));
      rst_n_s = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
